// File: rtl/song_sequencer_pkg.sv
// Command encodings and sequencer state shared by the song sequencer and its voice gates.
package song_sequencer_pkg;

    typedef enum logic [1:0] {
        CMD_HOLD     = 2'b00,
        CMD_NOTE_ON  = 2'b01,
        CMD_NOTE_OFF = 2'b10,
        CMD_END      = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_COMMIT,
        S_WAIT_TICK
    } state_e;

    function automatic cmd_e word_cmd(input logic [1:0] bits);
        return cmd_e'(bits);
    endfunction

endpackage

// File: rtl/gate_retrigger.sv
// One voice's ADSR gate: follows NOTE_ON/NOTE_OFF at commit and inserts a timed
// low pulse when a sounding voice is retriggered.
module gate_retrigger
    import song_sequencer_pkg::*;
#(
    parameter int RETRIG_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic kill,
    input  logic commit,
    input  cmd_e cmd,
    output logic gate
);

    localparam int CNT_BITS = $clog2(RETRIG_CYCLES + 1);

    logic [CNT_BITS-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate  <= 1'b0;
            count <= '0;
        end else if (kill) begin
            gate  <= 1'b0;
            count <= '0;
        end else if (commit && cmd == CMD_NOTE_ON) begin
            // A voice that is sounding, or still inside a retrigger gap, restarts the gap.
            if (gate || count != '0) begin
                gate  <= 1'b0;
                count <= CNT_BITS'(RETRIG_CYCLES);
            end else begin
                gate  <= 1'b1;
                count <= '0;
            end
        end else if (commit && cmd == CMD_NOTE_OFF) begin
            gate  <= 1'b0;
            count <= '0;
        end else if (count != '0) begin
            count <= count - CNT_BITS'(1);
            if (count == CNT_BITS'(1)) begin
                gate <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/song_sequencer.sv
// Row-based song sequencer: per tick, fetches one row of voice commands from a
// two-cycle-latency song ROM and commits all voices together.
module song_sequencer
    import song_sequencer_pkg::*;
#(
    parameter int VOICES        = 3,
    parameter int ROWS          = 32,
    parameter int FREQ_BITS     = 16,
    parameter int ADDR_BITS     = 7,
    parameter int RETRIG_CYCLES = 16,
    parameter int LOOP          = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          tick,
    input  logic                          run,
    output logic [ADDR_BITS-1:0]          rom_addr,
    input  logic [FREQ_BITS+1:0]          rom_data,
    output logic [VOICES*FREQ_BITS-1:0]   voice_freq,
    output logic [VOICES-1:0]             voice_gate,
    output logic [$clog2(ROWS)-1:0]       row_index,
    output logic                          row_strobe,
    output logic                          playing,
    output logic                          overrun
);

    localparam int ROW_BITS  = $clog2(ROWS);
    localparam int SLOT_BITS = $clog2(VOICES + 1);
    localparam int WORD_BITS = FREQ_BITS + 2;
    localparam logic [ROW_BITS-1:0]  LAST_ROW = ROW_BITS'(ROWS - 1);
    localparam logic [SLOT_BITS-1:0] SLOT_END = SLOT_BITS'(VOICES);

    state_e                 state;
    logic [ROW_BITS-1:0]    row;
    logic [SLOT_BITS-1:0]   slot;
    logic                   drain_second;
    logic                   run_d;
    logic                   stop_pending;
    logic                   issue_valid;
    logic [SLOT_BITS-1:0]   issue_slot;
    logic                   pipe_valid_1;
    logic                   pipe_valid_2;
    logic [SLOT_BITS-1:0]   pipe_slot_1;
    logic [SLOT_BITS-1:0]   pipe_slot_2;
    logic [VOICES-1:0]      end_vec;
    logic                   end_seen;
    logic                   commit_fire;
    logic                   kill;

    function automatic logic [ADDR_BITS-1:0] word_addr(input logic [ROW_BITS-1:0]  r,
                                                       input logic [SLOT_BITS-1:0] s);
        return ADDR_BITS'(r) * ADDR_BITS'(VOICES) + ADDR_BITS'(s);
    endfunction

    assign end_seen    = |end_vec;
    assign commit_fire = run && (state == S_COMMIT);
    // Gates drop on run loss, or one cycle after an end-of-song commit when not looping.
    assign kill        = !run || (state == S_IDLE && stop_pending);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            row          <= '0;
            slot         <= '0;
            drain_second <= 1'b0;
            run_d        <= 1'b0;
            stop_pending <= 1'b0;
            issue_valid  <= 1'b0;
            issue_slot   <= '0;
            rom_addr     <= '0;
            row_index    <= '0;
            row_strobe   <= 1'b0;
            playing      <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            run_d       <= run;
            row_strobe  <= 1'b0;
            issue_valid <= 1'b0;
            if (!run) begin
                state        <= S_IDLE;
                row          <= '0;
                slot         <= '0;
                drain_second <= 1'b0;
                stop_pending <= 1'b0;
                playing      <= 1'b0;
            end else begin
                if (tick && state != S_WAIT_TICK && state != S_IDLE) begin
                    overrun <= 1'b1;
                end
                case (state)
                    S_IDLE: begin
                        if (stop_pending) begin
                            playing      <= 1'b0;
                            stop_pending <= 1'b0;
                        end else if (!run_d) begin
                            playing     <= 1'b1;
                            overrun     <= 1'b0;
                            row         <= '0;
                            rom_addr    <= word_addr('0, '0);
                            issue_valid <= 1'b1;
                            issue_slot  <= '0;
                            slot        <= SLOT_BITS'(1);
                            state       <= S_FETCH;
                        end
                    end
                    S_FETCH: begin
                        // Voice 0 is issued on entry; the last FETCH cycle issues nothing.
                        if (slot == SLOT_END) begin
                            state <= S_DRAIN;
                        end else begin
                            rom_addr    <= word_addr(row, slot);
                            issue_valid <= 1'b1;
                            issue_slot  <= slot;
                            slot        <= slot + SLOT_BITS'(1);
                        end
                    end
                    S_DRAIN: begin
                        drain_second <= !drain_second;
                        if (drain_second) begin
                            state <= S_COMMIT;
                        end
                    end
                    S_COMMIT: begin
                        row_strobe <= 1'b1;
                        row_index  <= row;
                        if (end_seen) begin
                            row <= '0;
                            if (LOOP != 0) begin
                                state <= S_WAIT_TICK;
                            end else begin
                                state        <= S_IDLE;
                                stop_pending <= 1'b1;
                            end
                        end else begin
                            row   <= (row == LAST_ROW) ? '0 : row + ROW_BITS'(1);
                            state <= S_WAIT_TICK;
                        end
                    end
                    S_WAIT_TICK: begin
                        if (tick) begin
                            rom_addr    <= word_addr(row, '0);
                            issue_valid <= 1'b1;
                            issue_slot  <= '0;
                            slot        <= SLOT_BITS'(1);
                            state       <= S_FETCH;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // Tracks which voice slot each ROM word belongs to across the read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_valid_1 <= 1'b0;
            pipe_valid_2 <= 1'b0;
            pipe_slot_1  <= '0;
            pipe_slot_2  <= '0;
        end else if (!run) begin
            pipe_valid_1 <= 1'b0;
            pipe_valid_2 <= 1'b0;
        end else begin
            pipe_valid_1 <= issue_valid;
            pipe_slot_1  <= issue_slot;
            pipe_valid_2 <= pipe_valid_1;
            pipe_slot_2  <= pipe_slot_1;
        end
    end

    for (genvar gi = 0; gi < VOICES; gi++) begin : g_voice
        logic [WORD_BITS-1:0] shadow_word;
        logic [FREQ_BITS-1:0] freq_reg;
        cmd_e                 cmd;

        assign cmd         = word_cmd(shadow_word[WORD_BITS-1:FREQ_BITS]);
        assign end_vec[gi] = (cmd == CMD_END);
        assign voice_freq[gi*FREQ_BITS +: FREQ_BITS] = freq_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                shadow_word <= '0;
            end else if (pipe_valid_2 && pipe_slot_2 == SLOT_BITS'(gi)) begin
                shadow_word <= rom_data;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                freq_reg <= '0;
            end else if (commit_fire && cmd == CMD_NOTE_ON) begin
                freq_reg <= shadow_word[FREQ_BITS-1:0];
            end
        end

        gate_retrigger #(
            .RETRIG_CYCLES(RETRIG_CYCLES)
        ) u_gate (
            .clk    (clk),
            .rst_n  (rst_n),
            .kill   (kill),
            .commit (commit_fire),
            .cmd    (cmd),
            .gate   (voice_gate[gi])
        );
    end

endmodule

// File: doc/song_sequencer.md
# song_sequencer

Row-based song sequencer for tiny-synth voices. On each tick from the tempo divider it fetches one row of per-voice commands from a synchronous song ROM, then updates every voice's tone frequency and ADSR gate at the same instant so chords start together. Sits between the tick `clock_divider` strobe and the voice/envelope array whose mix feeds `pdm_dac`.

## Interface
- `VOICES`, 3: number of voices driven.
- `ROWS`, 32: rows in the song; row index wraps at `ROWS`.
- `FREQ_BITS`, 16: tone-generator frequency word width.
- `ADDR_BITS`, 7: song ROM address width; must hold `ROWS*VOICES`.
- `RETRIG_CYCLES`, 16: gate-low pulse length on retrigger.
- `LOOP`, 1: 1 = wrap to row 0 on end-of-song; 0 = stop.

- `clk` in 1: system clock (16 MHz).
- `rst_n` in 1: asynchronous, active-low reset.
- `tick` in 1: one-`clk` strobe per row.
- `run` in 1: level; high = play.
- `rom_addr` out ADDR_BITS: song ROM address, registered.
- `rom_data` in FREQ_BITS+2: `{cmd[1:0], freq}`, valid 2 `clk` after `rom_addr` changes.
- `voice_freq` out VOICES*FREQ_BITS: voice v at bits `[v*FREQ_BITS +: FREQ_BITS]`.
- `voice_gate` out VOICES: ADSR gates.
- `row_index` out $clog2(ROWS): row most recently committed.
- `row_strobe` out 1: one-cycle pulse on row commit.
- `playing` out 1: high from `run` rise until stop.
- `overrun` out 1: sticky; tick arrived while fetch in progress.

## Operation
- ROM word for (row r, voice v) at address `r*VOICES + v`.
- cmd: 00 HOLD (no change), 01 NOTE_ON (load freq, gate high), 10 NOTE_OFF (gate low, freq kept), 11 END (treated as HOLD for that voice; flags end-of-song).
- FSM: IDLE -> FETCH -> DRAIN -> COMMIT -> WAIT_TICK -> FETCH ...
  - IDLE: `run` low. On `run` rise: `playing`=1, row=0, go to FETCH immediately (no tick wait).
  - FETCH: issue addresses for voices 0..VOICES-1, one per cycle.
  - DRAIN: 2 cycles collecting trailing data into a shadow row buffer.
  - COMMIT: apply shadow buffer to outputs in one cycle; pulse `row_strobe`; `row_index`=row; compute next row.
  - WAIT_TICK: on `tick`, FETCH next row.
- Next row: END seen in any slot -> row 0 if `LOOP`=1, else all gates low, `playing`=0, IDLE. Otherwise row+1 mod `ROWS`.
- Retrigger: NOTE_ON on a voice whose gate is already high drives that gate low for `RETRIG_CYCLES` cycles from COMMIT, then high; freq updates at COMMIT. Per-voice down-counter; a new NOTE_ON restarts it; NOTE_OFF cancels it (gate stays low).
- `tick` outside WAIT_TICK: ignored, `overrun` set; cleared only by reset or `run` rise.
- `run` low in any state: next cycle all gates low, retrigger counters cleared, `playing`=0, row=0, IDLE; `voice_freq` retained. Also aborts a fetch.
- Simultaneous `run` fall and `tick`: `run` wins.

## Timing
- Reset: `rom_addr`=0, `voice_freq`=0, `voice_gate`=0, `row_index`=0, `row_strobe`=0, `playing`=0, `overrun`=0, FSM IDLE.
- Tick-to-commit latency: `tick` sampled at edge T; outputs change at edge T+VOICES+3 (6 for VOICES=3).
- `run` rise sampled at edge R: first commit at R+VOICES+3.
- All outputs registered; no combinational input-to-output path.
- Min tick period: VOICES+4 cycles; shorter triggers `overrun`.

## Structure
- Package `song_sequencer_pkg`: cmd encodings (CMD_HOLD, CMD_NOTE_ON, CMD_NOTE_OFF, CMD_END), FSM state enum.
- One sub-module natural: `gate_retrigger` (per voice: gate register + `RETRIG_CYCLES` down-counter), instantiated VOICES times.
- Song ROM external (iCE40 BRAM, `$readmemh`).

## Test plan
- Reset mid-play: assert `rst_n` low during FETCH -> all outputs zero, IDLE; no `row_strobe`.
- Chord: row 0 = NOTE_ON 0x0449/0x0564/0x0668, `run` rise -> after 6 cycles freqs equal those values, gates=3'b111 same cycle, one `row_strobe`, `row_index`=0.
- Note-off/hold: row 1 = {NOTE_OFF, HOLD, HOLD}, tick -> gate 3'b110, freqs unchanged, `row_index`=1.
- Retrigger: row 2 NOTE_ON 0x0500 on voice 1 (gated) -> voice 1 gate low exactly 16 cycles from commit, freq 0x0500 at commit.
- End/loop: END on row 3; `LOOP`=1 -> next commit `row_index`=0; `LOOP`=0 -> gates 0, `playing`=0 one cycle after row 3 commit.
- Overrun/abort: tick 2 cycles after prior tick -> `overrun`=1 sticky, commit count unchanged; `run` low mid-FETCH -> gates 0 next cycle, no commit.
